// File: rtl/result_router_pkg.sv
// Shared definitions for the writeback router: port-index type and skid-buffer state encoding.
package result_router_pkg;

    localparam int unsigned PORT_INDEX_WIDTH = 8;

    typedef logic [PORT_INDEX_WIDTH-1:0] port_index_t;

    typedef enum logic [1:0] {
        BufEmpty = 2'd0,
        BufOne   = 2'd1,
        BufFull  = 2'd2
    } buffer_state_t;

endpackage

// File: rtl/skid_buffer.sv
// Two-entry skid buffer for one destination: main register drives the output, skid absorbs
// the word that arrives while the destination stalls.
module skid_buffer
    import result_router_pkg::*;
#(
    parameter int unsigned PORT_WIDTH = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic [PORT_WIDTH-1:0] push_data,
    output logic                  ready,
    output logic                  valid,
    input  logic                  consume,
    output logic [PORT_WIDTH-1:0] data
);

    buffer_state_t         state_q, state_d;
    logic [PORT_WIDTH-1:0] main_q, main_d;
    logic [PORT_WIDTH-1:0] skid_q, skid_d;
    logic                  pop;

    // Both flags come straight from state, so ready never sees consume combinationally.
    assign ready = (state_q != BufFull);
    assign valid = (state_q != BufEmpty);
    assign data  = main_q;
    assign pop   = valid && consume;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            BufEmpty: begin
                if (push) begin
                    state_d = BufOne;
                    main_d  = push_data;
                end
            end
            BufOne: begin
                if (push && pop) begin
                    main_d = push_data;
                end else if (push) begin
                    state_d = BufFull;
                    skid_d  = push_data;
                end else if (pop) begin
                    state_d = BufEmpty;
                end
            end
            BufFull: begin
                if (pop) begin
                    state_d = BufOne;
                    main_d  = skid_q;
                end
            end
            default: state_d = BufEmpty;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= BufEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock) begin
        main_q <= main_d;
        skid_q <= skid_d;
    end

endmodule

// File: rtl/result_router.sv
// Writeback router: steers one valid/ready stream to NUMBER_PORTS skid-buffered destinations.
// Define ROUTER_RANGE_CHECK_EN to add the sticky selection_error output.
module result_router
    import result_router_pkg::*;
#(
    parameter int unsigned NUMBER_PORTS = 2,
    parameter int unsigned PORT_WIDTH   = 64
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            input_valid,
    output logic                            input_ready,
    input  logic [PORT_WIDTH-1:0]           input_data,
    input  logic [$clog2(NUMBER_PORTS)-1:0] input_port_selection,
    output logic [NUMBER_PORTS-1:0]         output_valid,
    input  logic [NUMBER_PORTS-1:0]         output_ready,
    output logic [PORT_WIDTH-1:0]           output_port [NUMBER_PORTS]
`ifdef ROUTER_RANGE_CHECK_EN
    ,
    output logic                            selection_error
`endif
);

    port_index_t             selection;
    logic [NUMBER_PORTS-1:0] buffer_ready;
    logic [NUMBER_PORTS-1:0] push;

    assign selection = port_index_t'(input_port_selection);

    // An unmatched (out-of-range) index keeps ready high and pushes nowhere: the word is dropped.
    always_comb begin
        input_ready = 1'b1;
        push        = '0;
        for (int i = 0; i < NUMBER_PORTS; i++) begin
            if (selection == port_index_t'(i)) begin
                input_ready = buffer_ready[i];
                push[i]     = input_valid && buffer_ready[i];
            end
        end
    end

`ifdef ROUTER_RANGE_CHECK_EN
    logic in_range;

    assign in_range = (selection < port_index_t'(NUMBER_PORTS));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            selection_error <= 1'b0;
        end else if (input_valid && !in_range) begin
            selection_error <= 1'b1;
        end
    end
`endif

    for (genvar i = 0; i < NUMBER_PORTS; i++) begin : g_port
        skid_buffer #(
            .PORT_WIDTH(PORT_WIDTH)
        ) u_buffer (
            .clock    (clock),
            .reset    (reset),
            .push     (push[i]),
            .push_data(input_data),
            .ready    (buffer_ready[i]),
            .valid    (output_valid[i]),
            .consume  (output_ready[i]),
            .data     (output_port[i])
        );
    end

endmodule

// File: tb/tb_result_router.sv
// Self-checking bench for result_router: directed scenarios plus randomized traffic against a
// per-port queue model. A second 3-port instance covers out-of-range selections.
module tb_result_router;

    localparam int NP = 2;
    localparam int W  = 64;
    localparam int W3 = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          input_valid = 1'b0;
    logic          input_ready;
    logic [W-1:0]  input_data = '0;
    logic [0:0]    input_port_selection = '0;
    logic [NP-1:0] output_valid;
    logic [NP-1:0] output_ready = '0;
    logic [W-1:0]  output_port [NP];

    logic          v3 = 1'b0;
    logic          r3;
    logic [W3-1:0] d3 = '0;
    logic [1:0]    s3 = '0;
    logic [2:0]    ov3;
    logic [2:0]    or3 = '1;
    logic [W3-1:0] op3 [3];

`ifdef ROUTER_RANGE_CHECK_EN
    logic selection_error;
    logic selection_error3;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clock = ~clock;

    result_router #(
        .NUMBER_PORTS(NP),
        .PORT_WIDTH  (W)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .input_valid         (input_valid),
        .input_ready         (input_ready),
        .input_data          (input_data),
        .input_port_selection(input_port_selection),
        .output_valid        (output_valid),
        .output_ready        (output_ready),
        .output_port         (output_port)
`ifdef ROUTER_RANGE_CHECK_EN
        ,
        .selection_error     (selection_error)
`endif
    );

    result_router #(
        .NUMBER_PORTS(3),
        .PORT_WIDTH  (W3)
    ) dut3 (
        .clock               (clock),
        .reset               (reset),
        .input_valid         (v3),
        .input_ready         (r3),
        .input_data          (d3),
        .input_port_selection(s3),
        .output_valid        (ov3),
        .output_ready        (or3),
        .output_port         (op3)
`ifdef ROUTER_RANGE_CHECK_EN
        ,
        .selection_error     (selection_error3)
`endif
    );

    // Reference model: each destination is a FIFO holding at most two words.
    logic [W-1:0] mq [NP][$];

    always @(posedge clock or posedge reset) begin : model
        logic push_ok;
        int   s;
        if (reset) begin
            for (int p = 0; p < NP; p++) mq[p].delete();
        end else begin
            s       = int'(input_port_selection);
            push_ok = input_valid && (mq[s].size() < 2);
            for (int p = 0; p < NP; p++) begin
                if (mq[p].size() > 0 && output_ready[p]) void'(mq[p].pop_front());
            end
            if (push_ok) mq[s].push_back(input_data);
        end
    end

    task automatic drain();
        @(negedge clock);
        input_valid  = 1'b0;
        output_ready = '1;
        repeat (3) @(negedge clock);
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        input_valid  = 1'b0;
        output_ready = '0;
        repeat (2) @(negedge clock);
        #1;
        tests_run++;
        if (output_valid !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_valid: got %b want 00", output_valid);
        end
        reset = 1'b0;
        @(negedge clock);
        #1;
        tests_run++;
        if (input_ready !== 1'b1 || output_valid !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_release: ready %b valid %b want 1 00", input_ready, output_valid);
        end
    endtask

    task automatic test_basic();
        @(negedge clock);
        output_ready         = '0;
        input_valid          = 1'b1;
        input_port_selection = 1'b1;
        input_data           = 64'hA5;
        #1;
        tests_run++;
        if (input_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_ready: got %b want 1", input_ready);
        end
        @(negedge clock);
        input_valid = 1'b0;
        #1;
        tests_run++;
        if (output_valid !== 2'b10 || output_port[1] !== 64'hA5) begin
            tests_failed++;
            $display("FAIL basic_route: valid %b data %0h want 10 a5", output_valid,
                     output_port[1]);
        end
    endtask

    task automatic test_backpressure();
        drain();
        output_ready         = 2'b00;
        input_valid          = 1'b1;
        input_port_selection = 1'b0;
        input_data           = 64'h1;
        @(negedge clock);
        input_data = 64'h2;
        #1;
        tests_run++;
        if (input_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_second_ready: got %b want 1", input_ready);
        end
        @(negedge clock);
        input_data = 64'h3;
        #1;
        tests_run++;
        if (input_ready !== 1'b0 || output_port[0] !== 64'h1) begin
            tests_failed++;
            $display("FAIL bp_full: ready %b data %0h want 0 1", input_ready, output_port[0]);
        end
        @(negedge clock);
        output_ready = 2'b01;
        #1;
        tests_run++;
        if (input_ready !== 1'b0 || output_port[0] !== 64'h1 || output_valid[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_stall_hold: ready %b data %0h want 0 1", input_ready,
                     output_port[0]);
        end
        @(negedge clock);
        #1;
        tests_run++;
        if (input_ready !== 1'b1 || output_port[0] !== 64'h2) begin
            tests_failed++;
            $display("FAIL bp_second_out: ready %b data %0h want 1 2", input_ready,
                     output_port[0]);
        end
        @(negedge clock);
        input_valid = 1'b0;
        #1;
        tests_run++;
        if (output_valid[0] !== 1'b1 || output_port[0] !== 64'h3) begin
            tests_failed++;
            $display("FAIL bp_third_out: valid %b data %0h want 1 3", output_valid[0],
                     output_port[0]);
        end
    endtask

    task automatic test_independent();
        drain();
        output_ready         = 2'b10;
        input_valid          = 1'b1;
        input_port_selection = 1'b0;
        input_data           = 64'h7;
        @(negedge clock);
        input_data = 64'h8;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            input_port_selection = 1'b1;
            input_data           = 64'(100 + k);
            #1;
            tests_run++;
            if (input_ready !== 1'b1 || output_valid[0] !== 1'b1 || output_port[0] !== 64'h7)
            begin
                tests_failed++;
                $display("FAIL indep_port0_k%0d: ready %b valid0 %b data0 %0h want 1 1 7", k,
                         input_ready, output_valid[0], output_port[0]);
            end
            if (k > 0) begin
                tests_run++;
                if (output_valid[1] !== 1'b1 || output_port[1] !== 64'(100 + k - 1)) begin
                    tests_failed++;
                    $display("FAIL indep_port1_k%0d: valid %b data %0d want 1 %0d", k,
                             output_valid[1], output_port[1], 100 + k - 1);
                end
            end
        end
        @(negedge clock);
        input_valid = 1'b0;
    endtask

    task automatic test_stream();
        logic [W-1:0] words [100];
        foreach (words[i]) words[i] = {$urandom, $urandom};
        drain();
        for (int i = 0; i < 100; i++) begin
            input_valid          = 1'b1;
            input_port_selection = 1'b1;
            input_data           = words[i];
            #1;
            tests_run++;
            if (input_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL stream_ready_%0d: got %b want 1", i, input_ready);
            end
            if (i > 0) begin
                tests_run++;
                if (output_valid[1] !== 1'b1 || output_port[1] !== words[i-1]) begin
                    tests_failed++;
                    $display("FAIL stream_out_%0d: valid %b data %0h want 1 %0h", i - 1,
                             output_valid[1], output_port[1], words[i-1]);
                end
            end
            @(negedge clock);
        end
        input_valid = 1'b0;
        #1;
        tests_run++;
        if (output_valid[1] !== 1'b1 || output_port[1] !== words[99]) begin
            tests_failed++;
            $display("FAIL stream_last: valid %b data %0h want 1 %0h", output_valid[1],
                     output_port[1], words[99]);
        end
    endtask

    task automatic test_reset_full();
        drain();
        output_ready = 2'b00;
        input_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            input_port_selection = 1'(i / 2);
            input_data           = 64'(200 + i);
            @(negedge clock);
        end
        input_valid = 1'b0;
        #1;
        tests_run++;
        if (output_valid !== 2'b11 || input_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_before_reset: valid %b ready %b want 11 0", output_valid,
                     input_ready);
        end
        #2;
        reset = 1'b1;
        #1;
        tests_run++;
        if (output_valid !== 2'b00) begin
            tests_failed++;
            $display("FAIL async_reset: valid %b want 00", output_valid);
        end
        @(negedge clock);
        reset = 1'b0;
        #1;
        tests_run++;
        if (input_ready !== 1'b1 || output_valid !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_full_release: ready %b valid %b want 1 00", input_ready,
                     output_valid);
        end
    endtask

    task automatic test_random();
        logic accepted;
        logic exp_ready;
        int   s;
        drain();
        accepted = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clock);
            // A word not yet accepted must be held with its selection unchanged.
            if (!(input_valid && !accepted)) begin
                input_valid          = ($urandom_range(0, 3) != 0);
                input_port_selection = 1'($urandom_range(0, 1));
                input_data           = {$urandom, $urandom};
            end
            output_ready = 2'($urandom);
            #1;
            s         = int'(input_port_selection);
            exp_ready = (mq[s].size() < 2);
            tests_run++;
            if (input_ready !== exp_ready) begin
                tests_failed++;
                $display("FAIL rand_ready_c%0d: got %b want %b", c, input_ready, exp_ready);
            end
            for (int p = 0; p < NP; p++) begin
                tests_run++;
                if (output_valid[p] !== (mq[p].size() > 0) ||
                    (mq[p].size() > 0 && output_port[p] !== mq[p][0])) begin
                    tests_failed++;
                    $display("FAIL rand_port%0d_c%0d: valid %b data %0h want %0d words", p, c,
                             output_valid[p], output_port[p], mq[p].size());
                end
            end
            accepted = input_valid && exp_ready;
        end
        @(negedge clock);
        input_valid = 1'b0;
    endtask

    task automatic test_range();
        @(negedge clock);
        or3 = '1;
        v3  = 1'b1;
        s3  = 2'd3;
        d3  = 16'hBEEF;
        #1;
        tests_run++;
        if (r3 !== 1'b1) begin
            tests_failed++;
            $display("FAIL range_ready: got %b want 1", r3);
        end
        @(negedge clock);
        v3 = 1'b0;
        #1;
        tests_run++;
        if (ov3 !== 3'b000) begin
            tests_failed++;
            $display("FAIL range_dropped: valid %b want 000", ov3);
        end
`ifdef ROUTER_RANGE_CHECK_EN
        tests_run++;
        if (selection_error3 !== 1'b1) begin
            tests_failed++;
            $display("FAIL range_error_set: got %b want 1", selection_error3);
        end
`endif
        @(negedge clock);
        v3 = 1'b1;
        s3 = 2'd2;
        d3 = 16'h1234;
        @(negedge clock);
        v3 = 1'b0;
        #1;
        tests_run++;
        if (ov3 !== 3'b100 || op3[2] !== 16'h1234) begin
            tests_failed++;
            $display("FAIL range_valid_port2: valid %b data %0h want 100 1234", ov3, op3[2]);
        end
        repeat (3) @(negedge clock);
`ifdef ROUTER_RANGE_CHECK_EN
        tests_run++;
        if (selection_error3 !== 1'b1 || selection_error !== 1'b0) begin
            tests_failed++;
            $display("FAIL range_error_sticky: err3 %b err2 %b want 1 0", selection_error3,
                     selection_error);
        end
`endif
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        tests_run++;
        if (r3 !== 1'b1 || ov3 !== 3'b000) begin
            tests_failed++;
            $display("FAIL range_after_reset: ready %b valid %b want 1 000", r3, ov3);
        end
`ifdef ROUTER_RANGE_CHECK_EN
        tests_run++;
        if (selection_error3 !== 1'b0) begin
            tests_failed++;
            $display("FAIL range_error_clear: got %b want 0", selection_error3);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_independent();
        test_stream();
        test_reset_full();
        test_random();
        test_range();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
